// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: state encoding and timing defaults for the UART transmit scheduler.
package uart_sched_pkg;
    localparam logic [2:0] S_FLUSH     = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_LAUNCH    = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_WAIT_NEXT = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;
    localparam int CLKS_PER_BIT     = 28;
    localparam int DEF_FRAME_CYCLES = 11 * CLKS_PER_BIT;
    localparam int DEF_TX_TIMEOUT   = 400;
    localparam int DEF_GAP_CYCLES   = CLKS_PER_BIT;
    localparam int TIMER_W          = 9;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational pick of the first set request at or after pointer+1 (wrapping).
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      pointer,
    output logic               valid,
    output logic [IW-1:0]      index
);
    logic [IW-1:0] j;
    // Scan farthest-first so the nearest candidate after the pointer is written last and wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        j = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IW'((int'(pointer) + k) % NUM_REQ);
            if (req[j]) begin
                valid = 1'b1;
                index = j;
            end
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter among NUM_REQ requesters with a per-message
// round-robin lock, launches one frame per byte and recovers from a stuck transmitter.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int PARITY_TYPE  = 0,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int TX_TIMEOUT   = DEF_TX_TIMEOUT,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    localparam int IW          = $clog2(NUM_REQ)
) (
    input  logic                 clk_3125,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [IW-1:0]        grant_id,
    output logic                 busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 parity_type,
    input  logic                 tx_done,
    output logic                 timeout_err
);
    logic [2:0]         state, state_n;
    logic [TIMER_W-1:0] cnt;
    logic [IW-1:0]      rr_ptr, grant_n, arb_idx;
    logic               arb_valid, done_q, done_edge, timeout, last_flag, abort;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req),
        .pointer (rr_ptr),
        .valid   (arb_valid),
        .index   (arb_idx)
    );

    assign done_edge   = tx_done & ~done_q;
    assign timeout     = cnt == TIMER_W'(TX_TIMEOUT);
    assign grant_n     = (state == S_IDLE) ? arb_idx : grant_id;
    assign abort       = (state_n == S_GAP) && (state == S_WAIT_NEXT || (state == S_WAIT_DONE && !done_edge));
    assign parity_type = PARITY_TYPE != 0;

    always_ff @(posedge clk_3125) begin
        if (reset) state <= S_FLUSH;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FLUSH:     state_n = (cnt == TIMER_W'(FRAME_CYCLES - 1)) ? S_IDLE : S_FLUSH;
            S_IDLE:      state_n = arb_valid ? S_LAUNCH : S_IDLE;
            S_LAUNCH:    state_n = S_WAIT_DONE;
            S_WAIT_DONE: state_n = done_edge ? (last_flag ? S_GAP : req[grant_id] ? S_LAUNCH : S_WAIT_NEXT)
                                             : timeout ? S_GAP : S_WAIT_DONE;
            S_WAIT_NEXT: state_n = req[grant_id] ? S_LAUNCH : timeout ? S_GAP : S_WAIT_NEXT;
            S_GAP:       state_n = (cnt == TIMER_W'(GAP_CYCLES - 1)) ? S_IDLE : S_GAP;
            default:     state_n = S_FLUSH;
        endcase
    end

    always_comb begin
        tx_start = state == S_LAUNCH;
        req_ack  = tx_start ? NUM_REQ'(1) << grant_id : '0;
        busy     = state != S_IDLE;
    end

    // The byte is captured on entry to LAUNCH so tx_data is already valid alongside tx_start.
    // done_q is forced high in LAUNCH so a tx_done level left over from the previous frame is not an edge.
    always_ff @(posedge clk_3125) begin
        if (reset) begin
            cnt         <= '0;
            done_q      <= 1'b0;
            last_flag   <= 1'b0;
            grant_id    <= '0;
            tx_data     <= 8'h00;
            timeout_err <= 1'b0;
            rr_ptr      <= IW'(NUM_REQ - 1);
        end else begin
            cnt         <= (state_n != state) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
            done_q      <= (state == S_LAUNCH) | tx_done;
            timeout_err <= timeout_err | abort;
            if (state_n == S_LAUNCH) begin
                grant_id  <= grant_n;
                tx_data   <= req_data[8*grant_n +: 8];
                last_flag <= req_last[grant_n];
            end
            if (state == S_WAIT_DONE && done_edge && last_flag) rr_ptr <= grant_id;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed scenarios against a UART transmitter model with an
// expected-launch scoreboard checked on every tx_start.
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;
    localparam int NUM_REQ = 3;
    localparam int FRAME   = DEF_FRAME_CYCLES;
    localparam int TOUT    = DEF_TX_TIMEOUT;
    localparam int GAP     = DEF_GAP_CYCLES;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic                   clk_3125 = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_REQ-1:0]     req = '0;
    logic [NUM_REQ-1:0]     req_last = '0;
    logic [8*NUM_REQ-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]     req_ack;
    logic [1:0]             grant_id;
    logic                   busy, tx_start, parity_type, timeout_err;
    logic [7:0]             tx_data;
    logic                   tx_done = 1'b1;

    logic [8:0] src [NUM_REQ][$];
    exp_t       sb[$];
    exp_t       cur;
    int cyc = 0, n_cmp = 0, n_fail = 0, n_start = 0, n_pushed = 0, n_rise = 0;
    int start_cyc = 0, done_rise_cyc = 0, msg_end_cyc = -1, frame_cnt = 0;
    int req_rise [NUM_REQ];
    bit launched = 1'b0, stuck = 1'b0, done_prev = 1'b1;

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clk_3125    (clk_3125),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .parity_type (parity_type),
        .tx_done     (tx_done),
        .timeout_err (timeout_err)
    );

    always #5 clk_3125 = ~clk_3125;

    always @(posedge clk_3125) cyc++;

    // UART transmitter model: tx_done drops after tx_start and rises FRAME clocks later unless stuck.
    always @(posedge clk_3125) begin
        if (tx_start) begin
            tx_done   <= 1'b0;
            frame_cnt <= FRAME;
        end else if (frame_cnt > 0) begin
            frame_cnt <= frame_cnt - 1;
            if (frame_cnt == 1 && !stuck) tx_done <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_cmp++;
        assert (obs === expd) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    // Requesters: present the head of their byte queue, advance on their ack.
    always @(negedge clk_3125) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i] && src[i].size() > 0) void'(src[i].pop_front());
            if (src[i].size() > 0) begin
                if (!req[i]) req_rise[i] = cyc;
                req[i]            = 1'b1;
                req_data[8*i +: 8] = src[i][0][7:0];
                req_last[i]       = src[i][0][8];
            end else begin
                req[i]            = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    end

    always @(negedge clk_3125) begin
        if (tx_start) begin
            n_start++;
            start_cyc = cyc;
            if (msg_end_cyc >= 0) check("gap after message", 32'(cyc - msg_end_cyc >= GAP + 2), 1);
            msg_end_cyc = -1;
            check("tx_start expected", 32'(n_start <= n_pushed), 1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                check("grant_id", 32'(grant_id), cur.id);
                check("tx_data at start", 32'(tx_data), 32'(cur.data));
                check("req_ack", 32'(req_ack), 32'(1 << cur.id));
                launched = 1'b1;
            end
        end
        if (tx_done && !done_prev) begin
            n_rise++;
            done_rise_cyc = cyc;
            if (launched) begin
                check("tx_data stable", 32'(tx_data), 32'(cur.data));
                if (cur.last) msg_end_cyc = cyc;
            end
            launched = 1'b0;
        end
        done_prev = tx_done;
    end

    task automatic push(input int id, input logic last, input logic [7:0] data);
        src[id].push_back({last, data});
        sb.push_back('{id, data, last});
        n_pushed++;
    endtask

    task automatic wait_sb(input string tag, input int target);
        int k = 0;
        while (sb.size() > target && k < 3000) begin @(negedge clk_3125); k++; end
        check(tag, 32'(sb.size() <= target), 1);
    endtask

    task automatic wait_rise(input string tag, input int r0);
        int k = 0;
        while (n_rise == r0 && k < 1000) begin @(negedge clk_3125); k++; end
        check(tag, 32'(n_rise != r0), 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((sb.size() > 0 || busy) && k < 5000) begin @(negedge clk_3125); k++; end
        check(tag, 32'(sb.size() == 0 && !busy), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " tx_start"}, 32'(tx_start), 0);
        check({tag, " req_ack"}, 32'(req_ack), 0);
        check({tag, " tx_data"}, 32'(tx_data), 0);
        check({tag, " grant_id"}, 32'(grant_id), 0);
        check({tag, " timeout_err"}, 32'(timeout_err), 0);
        check({tag, " busy"}, 32'(busy), 1);
    endtask

    task automatic flush_check(input string tag);
        int k = 0;
        int s0 = n_start;
        while (busy && k < 2 * FRAME) begin @(negedge clk_3125); k++; end
        check({tag, " length"}, k, FRAME);
        check({tag, " no tx_start"}, n_start, s0);
    endtask

    initial begin
        int r0, s0, t;
        repeat (3) @(negedge clk_3125);
        check_reset("reset");
        check("parity_type", 32'(parity_type), 0);
        reset = 1'b0;
        flush_check("flush");

        // Round robin from reset pointer: 0,1,2 then 0 again.
        @(posedge clk_3125); #1;
        push(0, 1'b1, 8'h10);
        push(1, 1'b1, 8'h20);
        push(2, 1'b1, 8'h30);
        push(0, 1'b1, 8'h11);
        wait_idle("round robin");

        // Single byte: launch the cycle after req is sampled, gap then idle.
        @(posedge clk_3125); #1;
        r0 = n_rise;
        push(1, 1'b1, 8'hA5);
        wait_sb("single start", 0);
        check("single latency", start_cyc - req_rise[1], 1);
        wait_rise("single done", r0);
        t = done_rise_cyc;
        while (busy && cyc - t < 200) @(negedge clk_3125);
        check("single gap to idle", cyc - t, GAP + 1);

        // Message lock: req0 three bytes while req2 waits.
        @(posedge clk_3125); #1;
        push(0, 1'b0, 8'hB1);
        push(0, 1'b0, 8'hB2);
        push(0, 1'b1, 8'hB3);
        wait_sb("lock first start", 2);
        push(2, 1'b1, 8'hC1);
        wait_idle("message lock");

        // Stall in mid-message, resumed after 100 clocks.
        @(posedge clk_3125); #1;
        r0 = n_rise;
        push(0, 1'b0, 8'h51);
        wait_sb("stall b1 start", 0);
        s0 = n_start;
        wait_rise("stall b1 done", r0);
        repeat (100) @(negedge clk_3125);
        check("stall holds busy", 32'(busy), 1);
        check("stall no start", n_start, s0);
        @(posedge clk_3125); #1;
        push(0, 1'b1, 8'h52);
        wait_idle("stall resume");
        check("stall no timeout", 32'(timeout_err), 0);

        // Abandoned message: timer restarts at the tx_done rise and aborts after TX_TIMEOUT.
        @(posedge clk_3125); #1;
        r0 = n_rise;
        push(0, 1'b0, 8'h61);
        wait_sb("abandon start", 0);
        wait_rise("abandon done", r0);
        while (!timeout_err && cyc - done_rise_cyc < TOUT + 50) @(negedge clk_3125);
        check("abandon timeout time", cyc - done_rise_cyc, TOUT + 2);
        t = cyc;
        while (busy && cyc - t < 200) @(negedge clk_3125);
        check("abandon gap", cyc - t, GAP);
        check("timeout sticky", 32'(timeout_err), 1);

        // Reset 100 clocks into a frame.
        @(posedge clk_3125); #1;
        push(2, 1'b1, 8'h99);
        wait_sb("midreset start", 0);
        repeat (100) @(negedge clk_3125);
        launched = 1'b0;
        reset = 1'b1;
        @(negedge clk_3125);
        reset = 1'b0;
        check_reset("midreset");
        flush_check("midreset flush");
        @(posedge clk_3125); #1;
        push(1, 1'b1, 8'h77);
        wait_idle("after reset");
        check("after reset no timeout", 32'(timeout_err), 0);

        // Stuck UART: tx_done never rises.
        stuck = 1'b1;
        @(posedge clk_3125); #1;
        push(1, 1'b1, 8'h3C);
        wait_sb("stuck start", 0);
        while (!timeout_err && cyc - start_cyc < TOUT + 50) @(negedge clk_3125);
        check("stuck timeout time", cyc - start_cyc, TOUT + 2);
        t = cyc;
        while (busy && cyc - t < 200) @(negedge clk_3125);
        check("stuck gap", cyc - t, GAP);
        check("stuck timeout_err", 32'(timeout_err), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed cycle %0d expected finish before limit", cyc);
        $fatal(1, "watchdog");
    end
endmodule
